// File: rtl/mdu_ctrl.sv
// Iterative MIPS multiply/divide unit with pipeline stall and HI/LO write sequencing.
// Optional MDU_FAST_MULT_EN: single-cycle combinational multiply; divide remains iterative.
module mdu_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             hilo_we,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;      // MUL: {partial hi, multiplier}; DIV: {remainder, dividend/quotient}
    logic [WIDTH-1:0]   opnd;     // multiplicand magnitude (MUL) or divisor magnitude (DIV)
    logic               neg_res;
    logic               neg_rem;
    logic               dbz_q;

    // Issue-time operand conditioning
    logic               a_neg, b_neg, div_zero_in;
    logic [WIDTH-1:0]   a_abs_in, b_abs_in;

    assign a_neg       = ~op[0] & src_a[WIDTH-1];
    assign b_neg       = ~op[0] & src_b[WIDTH-1];
    assign a_abs_in    = a_neg ? -src_a : src_a;
    assign b_abs_in    = b_neg ? -src_b : src_b;
    assign div_zero_in = op[1] & (src_b == '0);

    // One shift-add multiply step
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next, mul_fix;

    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};
    assign mul_fix  = neg_res ? -mul_next : mul_next;

    // One restoring-divide step
    logic [WIDTH:0]     div_shift, div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem, q_fix, r_fix;
    logic [2*WIDTH-1:0] div_next;

    assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd};
    assign div_ge    = (div_shift >= {1'b0, opnd});
    assign div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_next  = {div_rem, acc[WIDTH-2:0], div_ge};
    assign q_fix     = neg_res ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
    assign r_fix     = neg_rem ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];

`ifdef MDU_FAST_MULT_EN
    logic [2*WIDTH-1:0] fast_prod, fast_fix;
    assign fast_prod = {{WIDTH{1'b0}}, a_abs_in} * {{WIDTH{1'b0}}, b_abs_in};
    assign fast_fix  = (a_neg ^ b_neg) ? -fast_prod : fast_prod;
`endif

    // Pipeline-facing outputs; flush suppresses the write strobe in the same cycle
    assign stall       = ((state == S_IDLE) & start & ~flush) | (state == S_MUL) | (state == S_DIV);
    assign busy        = (state != S_IDLE);
    assign hilo_we     = (state == S_DONE) & ~flush;
    assign div_by_zero = dbz_q & hilo_we;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            acc     <= '0;
            opnd    <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            dbz_q   <= 1'b0;
            hi_out  <= '0;
            lo_out  <= '0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt     <= '0;
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        dbz_q   <= div_zero_in;
                        if (div_zero_in) begin
                            hi_out <= src_a;
                            lo_out <= '1;
                            state  <= S_DONE;
                        end else if (op[1]) begin
                            acc   <= {{WIDTH{1'b0}}, a_abs_in};
                            opnd  <= b_abs_in;
                            state <= S_DIV;
                        end else begin
`ifdef MDU_FAST_MULT_EN
                            {hi_out, lo_out} <= fast_fix;
                            state            <= S_DONE;
`else
                            acc   <= {{WIDTH{1'b0}}, b_abs_in};
                            opnd  <= a_abs_in;
                            state <= S_MUL;
`endif
                        end
                    end
                end
                S_MUL: begin
                    acc <= mul_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH-1)) begin
                        {hi_out, lo_out} <= mul_fix;
                        state            <= S_DONE;
                    end
                end
                S_DIV: begin
                    acc <= div_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH-1)) begin
                        hi_out <= r_fix;
                        lo_out <= q_fix;
                        state  <= S_DONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: stimulus queues expected HI/LO, a monitor checks each hilo_we.
module tb_mdu_ctrl;

`ifdef MDU_FAST_MULT_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a, src_b;
    logic        flush;
    logic        stall, busy, hilo_we, div_by_zero;
    logic [31:0] hi_out, lo_out;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    mdu_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .flush(flush), .stall(stall), .busy(busy), .hilo_we(hilo_we),
        .hi_out(hi_out), .lo_out(lo_out), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every HI/LO write must match the oldest outstanding expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (hilo_we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_hilo_we", 64'(hilo_we), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("hi_out", 64'(hi_out), 64'(e.hi));
                    check("lo_out", 64'(lo_out), 64'(e.lo));
                    check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
                end
            end
        end
    end

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                          input int lat, input string name);
        int we_cyc;
        int stalls;
        exp_q.push_back('{hi: ehi, lo: elo, dbz: edbz});
        last_hi = ehi;
        last_lo = elo;
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        #1;
        we_cyc = -1;
        stalls = 0;
        for (int c = 0; c < 100 && we_cyc < 0; c++) begin
            if (c > 0) begin
                @(negedge clk);
                start = 1'b0;
                #1;
            end
            if (stall) stalls++;
            if (hilo_we) we_cyc = c;
        end
        check({name, "_we_cycle"}, 64'(we_cyc), 64'(lat));
        check({name, "_stall_cycles"}, 64'(stalls), 64'(lat));
        @(negedge clk);
        #1;
        check({name, "_idle_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0; flush = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset_hi", 64'(hi_out), 64'd0);
        check("reset_lo", 64'(lo_out), 64'd0);
        check("reset_we", 64'(hilo_we), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_stall", 64'(stall), 64'd0);
        check("reset_dbz", 64'(div_by_zero), 64'd0);

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, MUL_LAT, "multu_max");
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, MUL_LAT, "mult_neg");
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, MUL_LAT, "mult_minmin");
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, MUL_LAT, "mult_m1m1");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, DIV_LAT, "div_neg");
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2,         32'h0000_0001, 32'h7FFF_FFFC, 1'b0, DIV_LAT, "divu");
        run_op(2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, DIV_LAT, "div_negdiv");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, DIV_LAT, "div_wrap");
        run_op(2'b11, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 1,       "divu_zero");
        run_op(2'b10, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 1,       "div_zero");

        // Flush mid-divide: no write, results hold, a start two cycles later is accepted
        @(negedge clk);
        start = 1'b1; op = 2'b10; src_a = 32'd1000; src_b = 32'd3;
        #1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 10) flush = 1'b1;
            #1;
        end
        check("flush_we_gated", 64'(hilo_we), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_idle", 64'(busy), 64'd0);
        check("flush_hi_hold", 64'(hi_out), 64'(last_hi));
        check("flush_lo_hold", 64'(lo_out), 64'(last_lo));
        run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, DIV_LAT, "after_flush");

        // Flush together with start in IDLE drops the request
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 2'b01; src_a = 32'd9; src_b = 32'd9;
        #1;
        check("flush_start_stall", 64'(stall), 64'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1;
        check("flush_start_idle", 64'(busy), 64'd0);

        // Asynchronous reset in the middle of a MULT
`ifdef MDU_FAST_MULT_EN
        exp_q.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFEB, dbz: 1'b0});
`endif
        @(negedge clk);
        start = 1'b1; op = 2'b00; src_a = 32'hFFFF_FFFD; src_b = 32'd7;
        #1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 5) rst = 1'b0;
            #1;
        end
        check("rst_mid_hi", 64'(hi_out), 64'd0);
        check("rst_mid_lo", 64'(lo_out), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_stall", 64'(stall), 64'd0);
        check("rst_mid_we", 64'(hilo_we), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_release_busy", 64'(busy), 64'd0);
        run_op(2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, MUL_LAT, "multu_after_rst");

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
